// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encodings, the bubble instruction, the default reset PC and the buffer entry layout.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INSN_NOP         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8002_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fetch_entry_t;

  // The 32-bit add drops the carry, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
  function automatic logic [31:0] next_pc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc,insn} entries that sits between instruction memory and decode.
// On a flush it can keep the head entry, which is how the branch delay slot survives a redirect.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic                   keep_head,
  input  fetch_entry_t           wdata,
  output fetch_entry_t           head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   base;
  logic [PTR_W-1:0]   wr_idx;

  // The entry count left standing once a flush has been applied; a push lands just after it.
  always_comb begin
    base = count_q;
    if (flush) begin
      base = (keep_head && count_q != '0) ? CNT_W'(1) : '0;
    end
    wr_idx = rd_ptr + base[PTR_W-1:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= base + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_idx] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ack and feeds decode from a small buffer.
// Optional FETCH_DELAY_SLOT_EN keeps the oldest sequential instruction across a redirect (MIPS delay slot).
//
// state       | meaning
// FETCH_IDLE  | no request outstanding; waiting for buffer room
// FETCH_REQ   | imem_req driven at fetch_pc; each ack pushes into the buffer
// FETCH_DRAIN | redirected mid-request; waiting out the old ack before fetching the target
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        insn_valid
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DS_EN = 1'b1;
`else
  localparam bit DS_EN = 1'b0;
`endif

  fetch_state_e       state_q, state_d;
  logic [31:0]        fetch_pc_q, fetch_pc_d;
  logic [31:0]        drain_addr_q, drain_addr_d;
  logic               keep_inflight_q, keep_inflight_d;
  logic               push, pop;
  fetch_entry_t       wdata, head;
  logic               full, empty;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     level_after;
  logic [31:0]        target;

  assign target = redirect_pc & ~32'h3;
  // A redirect suppresses the pop so the head is not consumed in the cycle that resteers fetch.
  assign pop    = !empty && !stall && !redirect;
  assign level_after = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

  always_comb begin
    state_d         = state_q;
    fetch_pc_d      = fetch_pc_q;
    drain_addr_d    = drain_addr_q;
    keep_inflight_d = keep_inflight_q;
    push            = 1'b0;
    wdata           = '{pc: fetch_pc_q, insn: imem_data};
    case (state_q)
      FETCH_IDLE: begin
        if (redirect) begin
          fetch_pc_d = target;
          state_d    = FETCH_REQ;
        end else if (!full || pop) begin
          state_d = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (redirect) begin
          fetch_pc_d = target;
          if (imem_ack) begin
            push    = DS_EN && empty;
            state_d = FETCH_REQ;
          end else begin
            drain_addr_d    = fetch_pc_q;
            keep_inflight_d = DS_EN && empty;
            state_d         = FETCH_DRAIN;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_pc(fetch_pc_q);
          state_d    = (level_after < (CNT_W+1)'(BUF_DEPTH)) ? FETCH_REQ : FETCH_IDLE;
        end
      end
      FETCH_DRAIN: begin
        wdata.pc = drain_addr_q;
        if (redirect) fetch_pc_d = target;
        if (imem_ack) begin
          push            = keep_inflight_q;
          keep_inflight_d = 1'b0;
          state_d         = FETCH_REQ;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= FETCH_IDLE;
      fetch_pc_q      <= RESET_PC;
      drain_addr_q    <= RESET_PC;
      keep_inflight_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fetch_pc_q      <= fetch_pc_d;
      drain_addr_q    <= drain_addr_d;
      keep_inflight_q <= keep_inflight_d;
    end
  end

  fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .keep_head (DS_EN),
    .wdata     (wdata),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign imem_req   = (state_q != FETCH_IDLE);
  assign imem_addr  = (state_q == FETCH_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign insn_valid = !empty;
  assign insn       = empty ? INSN_NOP : head.insn;
  assign pc         = empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; imem model returns ~addr after a configurable number of wait cycles.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h8002_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] insn, pc;
  logic        insn_valid;

  int nchk = 0;
  int nerr = 0;
  int lat_cfg = 0;
  int wait_cnt = 0;
  int ack_count = 0;
  logic req_seen;

  fetch_unit dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .insn(insn), .pc(pc), .insn_valid(insn_valid)
  );

  always #5 clock = ~clock;

  initial begin
    imem_ack  = 1'b0;
    imem_data = 32'h0;
    forever begin
      @(negedge clock);
      req_seen = imem_req;
      if (reset_n && imem_req && wait_cnt >= lat_cfg) begin
        imem_ack  = 1'b1;
        imem_data = ~imem_addr;
      end else begin
        imem_ack  = 1'b0;
        imem_data = 32'hDEAD_BEEF;
      end
      @(posedge clock);
      if (!reset_n) wait_cnt = 0;
      else if (imem_ack) begin
        wait_cnt = 0;
        ack_count++;
      end else if (req_seen) wait_cnt++;
    end
  end

  task automatic do_reset(input int lat);
    reset_n  = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    lat_cfg  = lat;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    lat_cfg = 0;
    @(negedge clock);
    nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    nchk++; if (imem_addr !== RPC) begin nerr++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RPC); end
    nchk++; if (insn_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got=%b exp=0", insn_valid); end
    nchk++; if (insn !== 32'h0 || pc !== 32'h0) begin nerr++; $display("FAIL rst_insn_pc got=%h/%h exp=0/0", insn, pc); end
  endtask

  // Scenarios 1 and 2 run back to back: streaming, then a 4-cycle stall with pc 8002_0004 at head.
  task automatic test_stream_and_stall();
    int acks0;
    do_reset(0);
    @(negedge clock);
    nchk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8002_0000) begin nerr++; $display("FAIL s1_addr0 got=%b/%h exp=1/80020000", imem_req, imem_addr); end
    nchk++; if (insn_valid !== 1'b0) begin nerr++; $display("FAIL s1_valid0 got=%b exp=0", insn_valid); end
    @(negedge clock);
    nchk++; if (imem_addr !== 32'h8002_0004) begin nerr++; $display("FAIL s1_addr1 got=%h exp=80020004", imem_addr); end
    nchk++; if (insn_valid !== 1'b1 || pc !== 32'h8002_0000 || insn !== ~32'h8002_0000) begin nerr++; $display("FAIL s1_out1 got=%b/%h/%h exp=1/80020000/7ffdffff", insn_valid, pc, insn); end
    @(negedge clock);
    nchk++; if (imem_addr !== 32'h8002_0008) begin nerr++; $display("FAIL s1_addr2 got=%h exp=80020008", imem_addr); end
    nchk++; if (pc !== 32'h8002_0004 || insn_valid !== 1'b1) begin nerr++; $display("FAIL s1_pc2 got=%h exp=80020004", pc); end
    acks0 = ack_count;
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      nchk++; if (insn_valid !== 1'b1 || pc !== 32'h8002_0004 || insn !== ~32'h8002_0004) begin nerr++; $display("FAIL s2_frozen%0d got=%b/%h/%h exp=1/80020004/7ffdfffb", i, insn_valid, pc, insn); end
      nchk++; if (imem_req !== 1'b0) begin nerr++; $display("FAIL s2_req%0d got=%b exp=0", i, imem_req); end
    end
    nchk++; if (ack_count - acks0 != 1) begin nerr++; $display("FAIL s2_acks got=%0d exp=1", ack_count - acks0); end
    stall = 1'b0;
    @(negedge clock);
    nchk++; if (pc !== 32'h8002_0008 || insn_valid !== 1'b1) begin nerr++; $display("FAIL s2_rel0 got=%b/%h exp=1/80020008", insn_valid, pc); end
    @(negedge clock);
    nchk++; if (pc !== 32'h8002_000C || insn_valid !== 1'b1) begin nerr++; $display("FAIL s2_rel1 got=%b/%h exp=1/8002000c", insn_valid, pc); end
  endtask

  task automatic test_drain();
    bit seen;
    do_reset(3);
    @(negedge clock);
    redirect_pc = 32'h0040_0100;
    redirect    = 1'b1;
    @(negedge clock);
    redirect = 1'b0;
    nchk++; if (imem_req !== 1'b1 || imem_addr !== 32'h8002_0000) begin nerr++; $display("FAIL s3_hold got=%b/%h exp=1/80020000", imem_req, imem_addr); end
    repeat (3) @(negedge clock);
    nchk++; if (imem_addr !== 32'h0040_0100 || insn_valid !== 1'b0) begin nerr++; $display("FAIL s3_target got=%h/%b exp=00400100/0", imem_addr, insn_valid); end
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clock);
      if (insn_valid) begin
        seen = 1'b1;
        nchk++; if (pc !== 32'h0040_0100 || insn !== ~32'h0040_0100) begin nerr++; $display("FAIL s3_first got=%h/%h exp=00400100/ffbffeff", pc, insn); end
      end
    end
    nchk++; if (!seen) begin nerr++; $display("FAIL s3_timeout got=no_valid exp=valid"); end
  endtask

  task automatic test_redirect_with_ack();
    do_reset(0);
    @(negedge clock);
    redirect_pc = 32'h0040_0203;
    redirect    = 1'b1;
    @(negedge clock);
    redirect = 1'b0;
    nchk++; if (imem_addr !== 32'h0040_0200 || insn_valid !== 1'b0) begin nerr++; $display("FAIL s4_addr got=%h/%b exp=00400200/0", imem_addr, insn_valid); end
    @(negedge clock);
    nchk++; if (insn_valid !== 1'b1 || pc !== 32'h0040_0200) begin nerr++; $display("FAIL s4_first got=%b/%h exp=1/00400200", insn_valid, pc); end
  endtask

  task automatic test_delay_slot();
    logic [31:0] got [2];
    logic [31:0] exp0, exp1;
    int n;
`ifdef FETCH_DELAY_SLOT_EN
    exp0 = 32'h8002_0010; exp1 = 32'h0040_0000;
`else
    exp0 = 32'h0040_0000; exp1 = 32'h0040_0004;
`endif
    do_reset(0);
    repeat (6) @(negedge clock);
    nchk++; if (pc !== 32'h8002_0010 || insn_valid !== 1'b1) begin nerr++; $display("FAIL s5_head got=%b/%h exp=1/80020010", insn_valid, pc); end
    redirect_pc = 32'h0040_0000;
    redirect    = 1'b1;
    @(negedge clock);
    redirect = 1'b0;
    n = 0;
    got[0] = 32'h0; got[1] = 32'h0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      if (insn_valid) begin
        got[n] = pc;
        n++;
      end
      if (n < 2) @(negedge clock);
    end
    nchk++; if (n != 2) begin nerr++; $display("FAIL s5_timeout got=%0d exp=2", n); end
    nchk++; if (got[0] !== exp0) begin nerr++; $display("FAIL s5_first got=%h exp=%h", got[0], exp0); end
    nchk++; if (got[1] !== exp1) begin nerr++; $display("FAIL s5_second got=%h exp=%h", got[1], exp1); end
  endtask

  task automatic test_wrap();
    do_reset(0);
    @(negedge clock);
    redirect_pc = 32'hFFFF_FFFC;
    redirect    = 1'b1;
    @(negedge clock);
    redirect = 1'b0;
    nchk++; if (imem_addr !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL s6_addr0 got=%h exp=fffffffc", imem_addr); end
    @(negedge clock);
    nchk++; if (imem_addr !== 32'h0000_0000 || pc !== 32'hFFFF_FFFC) begin nerr++; $display("FAIL s6_wrap got=%h/%h exp=00000000/fffffffc", imem_addr, pc); end
    @(negedge clock);
    nchk++; if (pc !== 32'h0000_0000 || insn !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL s6_pc got=%h/%h exp=00000000/ffffffff", pc, insn); end
  endtask

  task automatic test_reset_midreq();
    do_reset(0);
    repeat (4) @(negedge clock);
    nchk++; if (imem_req !== 1'b1 || insn_valid !== 1'b1) begin nerr++; $display("FAIL s7_pre got=%b/%b exp=1/1", imem_req, insn_valid); end
    #2 reset_n = 1'b0;
    #1;
    nchk++; if (imem_req !== 1'b0 || imem_addr !== RPC) begin nerr++; $display("FAIL s7_req got=%b/%h exp=0/%h", imem_req, imem_addr, RPC); end
    nchk++; if (insn_valid !== 1'b0 || insn !== 32'h0 || pc !== 32'h0) begin nerr++; $display("FAIL s7_out got=%b/%h/%h exp=0/0/0", insn_valid, insn, pc); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    nchk++; if (insn_valid !== 1'b0 || imem_addr !== RPC || imem_req !== 1'b1) begin nerr++; $display("FAIL s7_rel got=%b/%h/%b exp=0/%h/1", insn_valid, imem_addr, imem_req, RPC); end
    @(negedge clock);
    nchk++; if (insn_valid !== 1'b1 || pc !== RPC) begin nerr++; $display("FAIL s7_first got=%b/%h exp=1/%h", insn_valid, pc, RPC); end
  endtask

  initial begin
    test_reset();
    test_stream_and_stall();
    test_drain();
    test_redirect_with_ack();
    test_delay_slot();
    test_wrap();
    test_reset_midreq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
